// File: rtl/cdf_accumulate_stream.sv
// Streaming CDF accumulator: one histogram bin per beat in, inclusive running sum out one cycle later.
// Backpressure: a stalled output register blocks input (in_ready low); DONE also blocks input for one cycle.
module cdf_accumulate_stream #(
   parameter int COUNT_W  = 20,
   parameter int ADDR_W   = 16,
   parameter int NUM_BINS = 256
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COUNT_W-1:0] in_count,
   input  logic [ADDR_W-1:0]  in_addr,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COUNT_W-1:0] out_cdf,
   output logic [ADDR_W-1:0]  out_addr,
   output logic [COUNT_W-1:0] cdf_min,
   output logic               cdf_min_valid,
   output logic [COUNT_W-1:0] cdf_total,
   output logic               frame_done,
   output logic               frame_err,
   output logic               saturated
);

   localparam int BEAT_W = $clog2(NUM_BINS + 2);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t             state;
   logic               run;
   logic [COUNT_W-1:0] acc;
   logic [COUNT_W-1:0] acc_next;
   logic [COUNT_W:0]   sum;
   logic               clip;
   logic [BEAT_W-1:0]  beats;
   logic [BEAT_W-1:0]  beats_next;
   logic               min_found;
   logic               accept;

   // run keeps in_ready low while reset is asserted, so every output reads 0 in reset
   assign in_ready = run & (state != DONE) & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      sum        = {1'b0, acc} + {1'b0, in_count};
      clip       = sum[COUNT_W];
      acc_next   = clip ? '1 : sum[COUNT_W-1:0];
      beats_next = (beats == BEAT_W'(NUM_BINS + 1)) ? beats : beats + BEAT_W'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         run           <= 1'b0;
         acc           <= '0;
         beats         <= '0;
         min_found     <= 1'b0;
         out_valid     <= 1'b0;
         out_cdf       <= '0;
         out_addr      <= '0;
         cdf_min       <= '0;
         cdf_min_valid <= 1'b0;
         cdf_total     <= '0;
         frame_done    <= 1'b0;
         frame_err     <= 1'b0;
         saturated     <= 1'b0;
      end else begin
         run           <= 1'b1;
         cdf_min_valid <= 1'b0;
         frame_done    <= 1'b0;
         frame_err     <= 1'b0;
         if (clear) begin
            state     <= IDLE;
            acc       <= '0;
            beats     <= '0;
            min_found <= 1'b0;
            saturated <= 1'b0;
            out_valid <= 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               out_valid <= 1'b0;
            end
            case (state)
               DONE: begin
                  state     <= IDLE;
                  acc       <= '0;
                  beats     <= '0;
                  min_found <= 1'b0;
                  saturated <= 1'b0;
               end
               default: begin
                  if (accept) begin
                     acc       <= acc_next;
                     beats     <= beats_next;
                     out_valid <= 1'b1;
                     out_cdf   <= acc_next;
                     out_addr  <= in_addr;
                     if (clip) begin
                        saturated <= 1'b1;
                     end
                     // cdf_min of the previous frame survives until this frame's first beat
                     if (!min_found && acc_next != '0) begin
                        cdf_min       <= acc_next;
                        min_found     <= 1'b1;
                        cdf_min_valid <= 1'b1;
                     end else if (state == IDLE) begin
                        cdf_min <= '0;
                     end
                     if (in_last) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        frame_err  <= (beats_next != BEAT_W'(NUM_BINS));
                        cdf_total  <= acc_next;
                     end else begin
                        state <= ACCUM;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cdf_accumulate_stream.sv
// Randomised stream bench for cdf_accumulate_stream with a frame-level prefix-sum reference model.
module tb_cdf_accumulate_stream;

   localparam int     CW   = 20;
   localparam int     AW   = 16;
   localparam int     NB   = 6;
   localparam longint CMAX = (64'd1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_count = '0;
   logic [AW-1:0] in_addr = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [CW-1:0] out_cdf;
   logic [AW-1:0] out_addr;
   logic [CW-1:0] cdf_min;
   logic          cdf_min_valid;
   logic [CW-1:0] cdf_total;
   logic          frame_done;
   logic          frame_err;
   logic          saturated;

   cdf_accumulate_stream #(.COUNT_W(CW), .ADDR_W(AW), .NUM_BINS(NB)) dut (
      .clock(clock), .reset_n(reset_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
      .in_addr(in_addr), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_cdf(out_cdf), .out_addr(out_addr),
      .cdf_min(cdf_min), .cdf_min_valid(cdf_min_valid), .cdf_total(cdf_total),
      .frame_done(frame_done), .frame_err(frame_err), .saturated(saturated)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [CW-1:0] cdf;
      logic [AW-1:0] addr;
      logic          minv;
      logic [CW-1:0] mn;
      logic          sat;
   } beat_t;

   typedef struct {
      logic [CW-1:0] total;
      logic          err;
      logic          sat;
      logic [CW-1:0] mn;
   } frm_t;

   beat_t         exp_beats[$];
   frm_t          exp_frames[$];
   logic [CW-1:0] fc[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            n_out = 0;
   bit            mon_en = 0;
   bit            gap_en = 0;
   bit            rand_rdy = 0;
   bit            force_stall = 0;
   logic [CW-1:0] last_total = '0;
   logic [CW-1:0] abort_mn = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clock) begin
      #2;
      out_ready = force_stall ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   // Output monitor: each new output beat is matched against the model queue
   logic  prev_valid = 1'b0;
   logic  prev_hs = 1'b0;
   logic  nb;
   beat_t mb;
   frm_t  mf;
   always @(negedge clock) begin
      if (!mon_en) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         nb = out_valid && (!prev_valid || prev_hs);
         if (nb) begin
            if (exp_beats.size() == 0) begin
               chk("beats_pending", exp_beats.size(), 1);
            end else begin
               mb = exp_beats.pop_front();
               chk("out_cdf", 32'(out_cdf), 32'(mb.cdf));
               chk("out_addr", 32'(out_addr), 32'(mb.addr));
               chk("cdf_min_valid", 32'(cdf_min_valid), 32'(mb.minv));
               chk("cdf_min", 32'(cdf_min), 32'(mb.mn));
               chk("saturated", 32'(saturated), 32'(mb.sat));
               n_out++;
            end
         end else begin
            chk("min_pulse_idle", 32'(cdf_min_valid), 0);
            if (out_valid) begin
               chk("hold_cdf", 32'(out_cdf), 32'(mb.cdf));
               chk("hold_addr", 32'(out_addr), 32'(mb.addr));
            end
         end
         if (frame_done) begin
            if (exp_frames.size() == 0) begin
               chk("frames_pending", exp_frames.size(), 1);
            end else begin
               mf = exp_frames.pop_front();
               chk("cdf_total", 32'(cdf_total), 32'(mf.total));
               chk("frame_err", 32'(frame_err), 32'(mf.err));
               chk("frame_sat", 32'(saturated), 32'(mf.sat));
               chk("frame_min", 32'(cdf_min), 32'(mf.mn));
            end
         end
         prev_valid = out_valid;
         prev_hs    = out_valid && out_ready;
      end
   end

   task automatic send_beat(input logic [CW-1:0] c, input logic [AW-1:0] a, input logic l);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_count = c;
      in_addr  = a;
      in_last  = l;
      @(negedge clock);
      while (!in_ready && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 200) chk("in_ready_timeout", guard, 0);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gap_en) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   // Sends fc as one frame; abort_at (1-based) presents that beat together with clear instead
   task automatic send_frame(input int abort_at);
      longint        run_sum;
      logic [CW-1:0] mn;
      bit            found;
      bit            sat;
      int            n;
      int            upto;
      logic [AW-1:0] base;
      beat_t         b;
      frm_t          f;
      run_sum = 0;
      mn      = '0;
      found   = 0;
      sat     = 0;
      n       = fc.size();
      upto    = (abort_at != 0) ? abort_at - 1 : n;
      base    = AW'($urandom);
      for (int i = 0; i < upto; i++) begin
         run_sum += longint'(fc[i]);
         if (run_sum > CMAX) begin
            run_sum = CMAX;
            sat     = 1;
         end
         b.cdf  = CW'(run_sum);
         b.addr = base + AW'(i);
         b.minv = !found && run_sum != 0;
         if (b.minv) begin
            found = 1;
            mn    = CW'(run_sum);
         end
         b.mn  = mn;
         b.sat = sat;
         exp_beats.push_back(b);
      end
      if (abort_at == 0) begin
         f.total = CW'(run_sum);
         f.err   = (n != NB);
         f.sat   = sat;
         f.mn    = mn;
         exp_frames.push_back(f);
         last_total = f.total;
      end else begin
         abort_mn = mn;
      end
      for (int i = 0; i < upto; i++) send_beat(fc[i], base + AW'(i), i == n - 1);
      if (abort_at != 0) begin
         clear    = 1'b1;
         in_valid = 1'b1;
         in_count = fc[abort_at-1];
         in_addr  = base + AW'(abort_at - 1);
         @(posedge clock);
         #1;
         clear    = 1'b0;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_beats.size() != 0 || exp_frames.size() != 0) && g < 3000) begin
         @(negedge clock);
         g++;
      end
      if (g >= 3000) chk("drain_timeout", g, 0);
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_cdf"}, 32'(out_cdf), 0);
      chk({tag, "_out_addr"}, 32'(out_addr), 0);
      chk({tag, "_cdf_min"}, 32'(cdf_min), 0);
      chk({tag, "_cdf_min_valid"}, 32'(cdf_min_valid), 0);
      chk({tag, "_cdf_total"}, 32'(cdf_total), 0);
      chk({tag, "_frame_done"}, 32'(frame_done), 0);
      chk({tag, "_frame_err"}, 32'(frame_err), 0);
      chk({tag, "_saturated"}, 32'(saturated), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      #12;
      check_all_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      mon_en = 1;

      // Mixed zero/non-zero bins, exact frame length
      fc = '{20'd0, 20'd0, 20'd3, 20'd5, 20'd0, 20'd2};
      send_frame(0);
      drain();
      chk("t1_total", 32'(cdf_total), 10);
      chk("t1_min", 32'(cdf_min), 3);

      // Long all-zero frame: no min pulse, beat counter must not wrap
      fc.delete();
      for (int i = 0; i < 256; i++) fc.push_back('0);
      send_frame(0);
      drain();
      chk("t2_min", 32'(cdf_min), 0);
      chk("t2_total", 32'(cdf_total), 0);

      // Clipping, then a fresh frame that must start unsaturated
      fc = '{20'hFFFF0, 20'h00020, 20'h00001};
      send_frame(0);
      drain();
      chk("t3_total", 32'(cdf_total), 32'hFFFFF);
      fc = '{20'd1, 20'd2};
      send_frame(0);
      drain();
      chk("t3_next_sat", 32'(saturated), 0);

      // Output stall mid-frame
      fc = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6};
      s = n_out;
      fork
         send_frame(0);
         begin
            int g;
            g = 0;
            while (n_out < s + 3 && g < 100) begin
               @(negedge clock);
               g++;
            end
            @(posedge clock);
            #1;
            force_stall = 1;
            repeat (3) begin
               @(negedge clock);
               chk("stall_in_ready", 32'(in_ready), 0);
               chk("stall_out_valid", 32'(out_valid), 1);
            end
            force_stall = 0;
         end
      join
      drain();
      chk("t4_total", 32'(cdf_total), 21);

      // Short and long frames
      fc = '{20'd1, 20'd1, 20'd1, 20'd1, 20'd1};
      send_frame(0);
      fc = '{20'd2, 20'd2, 20'd2, 20'd2, 20'd2, 20'd2, 20'd2};
      send_frame(0);
      drain();

      // Abort with clear on beat 3, then a clean frame
      fc = '{20'd4, 20'd0, 20'd7, 20'd1, 20'd1, 20'd1};
      send_frame(3);
      repeat (4) @(negedge clock);
      chk("clr_out_valid", 32'(out_valid), 0);
      chk("clr_min_kept", 32'(cdf_min), 32'(abort_mn));
      chk("clr_total_kept", 32'(cdf_total), 32'(last_total));
      chk("clr_sat", 32'(saturated), 0);
      chk("clr_beats_left", exp_beats.size(), 0);
      @(posedge clock);
      #1;
      fc = '{20'd2, 20'd3, 20'd0, 20'd0, 20'd0, 20'd1};
      send_frame(0);
      drain();
      chk("t6_total", 32'(cdf_total), 6);

      // Random back-to-back frames with input gaps and output throttling
      gap_en   = 1;
      rand_rdy = 1;
      repeat (14) begin
         int n;
         n = $urandom_range(1, 9);
         fc.delete();
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) fc.push_back(CW'($urandom_range(32'(CMAX), 32'(CMAX / 2))));
            else fc.push_back(CW'($urandom_range(0, 3)));
         end
         send_frame(0);
      end
      drain();
      gap_en   = 0;
      rand_rdy = 0;
      repeat (2) @(posedge clock);
      #1;

      // Asynchronous reset mid-frame
      mon_en   = 0;
      in_valid = 1'b1;
      in_count = 20'd9;
      in_addr  = 16'd5;
      repeat (3) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      mon_en = 1;
      fc = '{20'd1, 20'd1, 20'd1, 20'd1, 20'd1, 20'd1};
      send_frame(0);
      drain();
      chk("post_reset_total", 32'(cdf_total), 6);

      chk("beats_left", exp_beats.size(), 0);
      chk("frames_left", exp_frames.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
